updown_count_scheduler: RTL and testbench

Sequencer and arbiter for the shared up/down counter. Two requesters each submit a command of direction plus step count over a valid/ready handshake. The block grants one command at a time using round-robin, then steps the embedded counter once per clock until the command completes. When it finishes, it pulses `done` tagged with the owning requester.

---
 rtl/counter_pkg.sv | 16 +
 rtl/updown_counter_core.sv | 31 +++
 rtl/updown_count_scheduler.sv | 133 +++++++++++++
 tb/tb_updown_count_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared states and constants for the up/down counter scheduler
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/updown_counter_core.sv
// rtl/updown_counter_core.sv - WIDTH-bit wrapping up/down counter
module updown_counter_core
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             updown,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Natural modulo-2^WIDTH wrap in both directions; no saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      if (updown == DIR_UP) begin
        r_count <= r_count + WIDTH'(1);
      end else begin
        r_count <= r_count - WIDTH'(1);
      end
    end
  end

  assign count = r_count;

endmodule

// File: rtl/updown_count_scheduler.sv
// rtl/updown_count_scheduler.sv - round-robin arbiter and sequencer driving the shared counter
module updown_count_scheduler
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_a,
  input  logic              req_dir_a,
  input  logic [STEP_W-1:0] req_steps_a,
  output logic              req_ready_a,
  input  logic              req_valid_b,
  input  logic              req_dir_b,
  input  logic [STEP_W-1:0] req_steps_b,
  output logic              req_ready_b,
  output logic [WIDTH-1:0]  count,
  output logic              updown,
  output logic              busy,
  output logic              owner,
  output logic              done,
  output logic              done_id
);

  sched_state_t      r_state;
  sched_state_t      w_next;
  logic              r_updown;
  logic              r_owner;
  logic              r_busy;
  logic              r_done;
  logic              r_done_id;
  logic              r_last;
  logic [STEP_W-1:0] r_remaining;

  logic              w_any;
  logic              w_sel;
  logic              w_sel_dir;
  logic [STEP_W-1:0] w_sel_steps;
  logic              w_xfer;
  logic              w_enable;

  // On contention the requester not granted last wins; r_last resets to B so A goes first.
  always_comb begin
    w_any = req_valid_a | req_valid_b;
    if (req_valid_a && req_valid_b) begin
      w_sel = ~r_last;
    end else if (req_valid_b) begin
      w_sel = REQ_B;
    end else begin
      w_sel = REQ_A;
    end
    w_sel_dir   = (w_sel == REQ_B) ? req_dir_b : req_dir_a;
    w_sel_steps = (w_sel == REQ_B) ? req_steps_b : req_steps_a;
  end

  assign w_xfer      = (r_state == IDLE) && w_any;
  assign req_ready_a = w_xfer && (w_sel == REQ_A);
  assign req_ready_b = w_xfer && (w_sel == REQ_B);
  assign w_enable    = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_next = (w_sel_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (r_remaining == STEP_W'(1)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_updown    <= DIR_DOWN;
      r_owner     <= REQ_A;
      r_remaining <= '0;
      r_last      <= REQ_B;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= REQ_A;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      if (w_xfer) begin
        r_updown    <= w_sel_dir;
        r_remaining <= w_sel_steps;
        r_owner     <= w_sel;
      end else if (w_enable) begin
        r_remaining <= r_remaining - STEP_W'(1);
      end
      // A zero-step command enters DONE straight from IDLE, before r_owner is loaded.
      if (w_next == DONE) begin
        r_done_id <= w_xfer ? w_sel : r_owner;
      end
      if (r_state == DONE) begin
        r_last <= r_owner;
      end
    end
  end

  updown_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .enable (w_enable),
    .updown (r_updown),
    .count  (count)
  );

  assign updown  = r_updown;
  assign busy    = r_busy;
  assign owner   = r_owner;
  assign done    = r_done;
  assign done_id = r_done_id;

endmodule

// File: tb/tb_updown_count_scheduler.sv
// tb/tb_updown_count_scheduler.sv - randomized scoreboard bench for updown_count_scheduler
module tb_updown_count_scheduler;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 4;
  localparam int MOD    = 1 << WIDTH;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid_a = 1'b0;
  logic              req_dir_a = 1'b0;
  logic [STEP_W-1:0] req_steps_a = '0;
  logic              req_ready_a;
  logic              req_valid_b = 1'b0;
  logic              req_dir_b = 1'b0;
  logic [STEP_W-1:0] req_steps_b = '0;
  logic              req_ready_b;
  logic [WIDTH-1:0]  count;
  logic              updown;
  logic              busy;
  logic              owner;
  logic              done;
  logic              done_id;

  updown_count_scheduler #(
    .WIDTH(WIDTH),
    .STEP_W(STEP_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_a (req_valid_a),
    .req_dir_a   (req_dir_a),
    .req_steps_a (req_steps_a),
    .req_ready_a (req_ready_a),
    .req_valid_b (req_valid_b),
    .req_dir_b   (req_dir_b),
    .req_steps_b (req_steps_b),
    .req_ready_b (req_ready_b),
    .count       (count),
    .updown      (updown),
    .busy        (busy),
    .owner       (owner),
    .done        (done),
    .done_id     (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint t;
    int     id;
    int     cnt;
  } exp_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;

  // Requester-side pending commands (held until accepted).
  bit     pa = 0, pb = 0;
  int     da = 0, db = 0, na = 0, nb = 0;

  // Reference model: a command of N steps accepted at time t0 completes at t0+(N+1)*10
  // and frees the arbiter at t0+(N+2)*10; count moves linearly in between.
  int     m_count = 0;
  int     m_last = 1;
  bit     act = 0;
  longint t0 = 0, free_t = 0;
  int     st = 0, dr = 0, nn = 0, cur_id = 0;
  bit     auto_a = 0, rand_mode = 0;

  function automatic int wr(input int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  function automatic int rnd_steps();
    if ($urandom_range(0, 9) == 0) return 15;
    return int'($urandom_range(0, 5));
  endfunction

  task automatic chk(input string nm, input int act_v, input int exp_v);
    checks++;
    if (act_v != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act_v, exp_v, $time);
    end
  endtask

  task automatic post(input int id, input int dir, input int steps);
    if (id == 0) begin
      pa = 1; da = dir; na = steps;
    end else begin
      pb = 1; db = dir; nb = steps;
    end
  endtask

  task automatic step(input bit do_rst);
    longint now;
    int     j, exp_cnt, sel;
    bit     exp_busy, ok;
    exp_t   keep[$];
    @(negedge clk);
    now = $time;
    if (act && now < free_t) begin
      exp_busy = 1;
      j = int'((now - t0) / 10) - 1;
      if (j > nn) j = nn;
      exp_cnt = wr(st + ((dr != 0) ? j : -j));
    end else begin
      exp_busy = 0;
      act = 0;
      exp_cnt = m_count;
    end
    chk("busy", int'(busy), int'(exp_busy));
    chk("count", int'(count), exp_cnt);
    if (exp_busy) begin
      chk("owner", int'(owner), cur_id);
      chk("updown", int'(updown), dr);
    end
    if (rand_mode) begin
      if (!pa && $urandom_range(0, 3) == 0) post(0, int'($urandom_range(0, 1)), rnd_steps());
      if (!pb && $urandom_range(0, 3) == 0) post(1, int'($urandom_range(0, 1)), rnd_steps());
    end
    if (auto_a && !pa) post(0, 1, 1);
    reset       = do_rst;
    req_valid_a = pa && !do_rst;
    req_dir_a   = da[0];
    req_steps_a = STEP_W'(na);
    req_valid_b = pb && !do_rst;
    req_dir_b   = db[0];
    req_steps_b = STEP_W'(nb);
    #1;
    ok  = !do_rst && (now >= free_t) && (pa || pb);
    sel = (pa && pb) ? (1 - m_last) : (pb ? 1 : 0);
    chk("ready_a", int'(req_ready_a), int'(ok && sel == 0));
    chk("ready_b", int'(req_ready_b), int'(ok && sel == 1));
    if (ok) begin
      st      = m_count;
      cur_id  = sel;
      dr      = (sel == 1) ? db : da;
      nn      = (sel == 1) ? nb : na;
      m_count = wr(st + ((dr != 0) ? nn : -nn));
      t0      = now;
      free_t  = now + longint'((nn + 2) * 10);
      act     = 1;
      m_last  = sel;
      sbq.push_back('{now + longint'((nn + 1) * 10), sel, m_count});
      if (sel == 0) pa = 0;
      else pb = 0;
    end
    if (do_rst) begin
      m_count = 0;
      m_last  = 1;
      act     = 0;
      free_t  = now + 10;
      pa      = 0;
      pb      = 0;
      foreach (sbq[i]) if (sbq[i].t <= now) keep.push_back(sbq[i]);
      sbq = keep;
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].t < $time) begin
        checks++;
        errors++;
        $display("FAIL done_missing: got no done, expected done at %0d (now %0t)", sbq[0].t, $time);
        void'(sbq.pop_front());
      end
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done=1 expected done=0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("done_time", int'($time), int'(e.t));
          chk("done_id", int'(done_id), e.id);
          chk("done_count", int'(count), e.cnt);
        end
      end
    end
  end

  initial begin
    repeat (3) step(1);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_owner", int'(owner), 0);
    chk("rst_updown", int'(updown), 0);

    post(0, 1, 3); repeat (7) step(0);
    post(0, 0, 2); repeat (6) step(0);
    post(1, 0, 3); repeat (7) step(0);

    step(1);
    post(0, 1, 2); post(1, 0, 2); repeat (3) step(0);
    post(0, 1, 1); repeat (12) step(0);

    post(0, 1, 0); repeat (5) step(0);

    post(0, 1, 10); repeat (6) step(0);
    step(1);
    post(0, 1, 1); post(1, 1, 1); repeat (10) step(0);

    auto_a = 1; repeat (21) step(0); auto_a = 0; repeat (5) step(0);

    rand_mode = 1;
    repeat (1500) step($urandom_range(0, 149) == 0);
    rand_mode = 0;
    repeat (45) step(0);

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
